// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - 64b/66b encoder constants shared by the TX scrambler/gearbox stage
//
// Purpose: sync-header codes, scrambler taps and gearbox sequence limits used
//          by the encoder datapath, the TX scrambler/gearbox and RX bench models.
// Contents:
//   SYNC_DATA / SYNC_CTL   2-bit 64b/66b sync headers
//   SCR_TAP_A / SCR_TAP_B  x^58 + x^39 + 1 scrambler taps
//   SCR_STATE_W            scrambler history width
//   GB_SEQ_MAX             last value of the GT external gearbox sequence
//   gb_phase_e             which half of a 64-bit block the gearbox is on
//   gb_is_pause()          true on the gearbox pause count
`timescale 1ns/1ps
package encoder_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTL  = 2'b10;

  localparam int SCR_TAP_A   = 39;
  localparam int SCR_TAP_B   = 58;
  localparam int SCR_STATE_W = 58;

  localparam logic [5:0] GB_SEQ_MAX = 6'd32;

  typedef enum logic {
    PH_LOWER = 1'b0,
    PH_UPPER = 1'b1
  } gb_phase_e;

  function automatic logic gb_is_pause(input logic [5:0] seq);
    return seq == GB_SEQ_MAX;
  endfunction

endpackage

// File: rtl/scrambler_64b.sv
// rtl/scrambler_64b.sv - combinational x^58+x^39+1 self-synchronous scrambler, 64 bits per call
//
// Purpose: scrambles one 64-bit block, bit 0 first, against the previous 58
//          scrambled bits. Pure combinational so it can be shared by the TX
//          datapath and by descrambler models.
// Ports:
//   data     in  64  plain block, bit 0 transmitted first
//   state_in in  58  last 58 scrambled bits, state_in[57] most recent
//   scr      out 64  scrambled block; next state is scr[63:6]
`timescale 1ns/1ps
module scrambler_64b
  import encoder_pkg::*;
(
  input  logic [63:0]            data,
  input  logic [SCR_STATE_W-1:0] state_in,
  output logic [63:0]            scr
);

  localparam int A = SCR_TAP_A;
  localparam int W = SCR_STATE_W;

  // s[i] = d[i] ^ s[i-39] ^ s[i-58], with s[-k] = state_in[58-k].
  // The recurrence is split into three slices so no vector feeds itself:
  //   i = 0..38   both taps land in state_in
  //   i = 39..57  the 39-tap lands in s_lo, the 58-tap in state_in
  //   i = 58..63  both taps land in s_lo
  logic [A-1:0]  s_lo;
  logic [W-A-1:0] s_mid;
  logic [63-W:0] s_hi;

  always_comb begin
    s_lo  = data[A-1:0] ^ state_in[W-1:W-A] ^ state_in[A-1:0];
    s_mid = data[W-1:A] ^ s_lo[W-A-1:0]     ^ state_in[W-1:A];
    s_hi  = data[63:W]  ^ s_lo[63-A:W-A]    ^ s_lo[63-W:0];
    scr   = {s_hi, s_mid, s_lo};
  end

endmodule

// File: rtl/tx_scramble_gearbox.sv
// rtl/tx_scramble_gearbox.sv - TX scrambler and 64-to-32 GT external-sequence gearbox
//
// Purpose: scrambles each 64-bit encoded block (header left clear), splits it
//          into two 32-bit GT words and runs the 0..32 gearbox sequence whose
//          last count is a pause the upstream stages honour.
// Ports:
//   i_txc            in  1   TX user clock, 32-bit word rate
//   i_reset_n        in  1   asynchronous active-low reset
//   i_init_done      in  1   link init complete; low holds the stage idle
//   i_txd            in  64  encoded block, held for both halves of the block
//   i_tx_header      in  2   sync header of that block
//   o_tx_pause       out 1   upstream must hold its word this cycle
//   o_gt_txd         out 32  GT TX data word
//   o_gt_txheader    out 2   GT TX header, meaningful on lower-half words
//   o_gt_txsequence  out 6   GT gearbox sequence carried with each word
`timescale 1ns/1ps
module tx_scramble_gearbox
  import encoder_pkg::*;
#(
  parameter bit                     SCR_BYPASS = 1'b0,
  parameter logic [SCR_STATE_W-1:0] SCR_SEED   = {SCR_STATE_W{1'b1}}
) (
  input  logic        i_txc,
  input  logic        i_reset_n,
  input  logic        i_init_done,
  input  logic [63:0] i_txd,
  input  logic [1:0]  i_tx_header,
  output logic        o_tx_pause,
  output logic [31:0] o_gt_txd,
  output logic [1:0]  o_gt_txheader,
  output logic [5:0]  o_gt_txsequence
);

  logic [5:0]             seq_q, seq_d;
  gb_phase_e              phase_q, phase_d;
  logic [SCR_STATE_W-1:0] state_q, state_d;
  logic [31:0]            upper_q, upper_d;
  logic [31:0]            txd_q, txd_d;
  logic [1:0]             hdr_q, hdr_d;

  logic [63:0] scr;
  logic [63:0] scr_sel;
  logic        pause;

  scrambler_64b u_scrambler (
    .data     (i_txd),
    .state_in (state_q),
    .scr      (scr)
  );

  // Bypass still advances the history from the transmitted bits, so
  // switching the build back on later keeps the same state semantics.
  assign scr_sel = SCR_BYPASS ? i_txd : scr;
  assign pause   = gb_is_pause(seq_q);

  always_comb begin
    seq_d   = seq_q;
    phase_d = phase_q;
    state_d = state_q;
    upper_d = upper_q;
    txd_d   = txd_q;
    hdr_d   = hdr_q;

    if (!i_init_done) begin
      // Any partially sent block is abandoned; restart cleanly at seq 0.
      seq_d   = '0;
      phase_d = PH_LOWER;
      state_d = SCR_SEED;
      upper_d = '0;
      txd_d   = '0;
      hdr_d   = SYNC_CTL;
    end else begin
      seq_d = pause ? 6'd0 : seq_q + 6'd1;
      // The pause count freezes the whole datapath; 32 non-pause counts are
      // exactly 16 blocks, so the pause always falls on a block boundary.
      if (!pause) begin
        phase_d = (phase_q == PH_LOWER) ? PH_UPPER : PH_LOWER;
        if (phase_q == PH_UPPER) begin
          txd_d   = scr_sel[31:0];
          hdr_d   = i_tx_header;
          upper_d = scr_sel[63:32];
          state_d = scr_sel[63:64-SCR_STATE_W];
        end else begin
          txd_d   = upper_q;
        end
      end
    end
  end

  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seq_q   <= '0;
      phase_q <= PH_LOWER;
      state_q <= SCR_SEED;
      upper_q <= '0;
      txd_q   <= '0;
      hdr_q   <= SYNC_CTL;
    end else begin
      seq_q   <= seq_d;
      phase_q <= phase_d;
      state_q <= state_d;
      upper_q <= upper_d;
      txd_q   <= txd_d;
      hdr_q   <= hdr_d;
    end
  end

  assign o_tx_pause      = pause;
  assign o_gt_txd        = txd_q;
  assign o_gt_txheader   = hdr_q;
  assign o_gt_txsequence = seq_q;

endmodule

// File: tb/tb_tx_scramble_gearbox.sv
// tb/tb_tx_scramble_gearbox.sv - scoreboard bench for tx_scramble_gearbox (scrambled and bypass builds)
`timescale 1ns/1ps
module tb_tx_scramble_gearbox;
  import encoder_pkg::*;

  localparam logic [57:0] SEED = {58{1'b1}};

  typedef struct {
    logic [63:0] blk;
    logic [1:0]  hdr;
    bit          chk;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_init_done;
  logic [63:0] i_txd;
  logic [1:0]  i_tx_header;

  logic        m_pause, b_pause;
  logic [31:0] m_txd, b_txd;
  logic [1:0]  m_hdr, b_hdr;
  logic [5:0]  m_seq, b_seq;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic active_at_edge;
  int   spos;

  always #5 clk = ~clk;

  tx_scramble_gearbox u_dut (
    .i_txc           (clk),
    .i_reset_n       (i_reset_n),
    .i_init_done     (i_init_done),
    .i_txd           (i_txd),
    .i_tx_header     (i_tx_header),
    .o_tx_pause      (m_pause),
    .o_gt_txd        (m_txd),
    .o_gt_txheader   (m_hdr),
    .o_gt_txsequence (m_seq)
  );

  tx_scramble_gearbox #(.SCR_BYPASS(1'b1)) u_byp (
    .i_txc           (clk),
    .i_reset_n       (i_reset_n),
    .i_init_done     (i_init_done),
    .i_txd           (i_txd),
    .i_tx_header     (i_tx_header),
    .o_tx_pause      (b_pause),
    .o_gt_txd        (b_txd),
    .o_gt_txheader   (b_hdr),
    .o_gt_txsequence (b_seq)
  );

  // Whether the DUT was free to advance at the most recent clock edge.
  always @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) active_at_edge <= 1'b0;
    else            active_at_edge <= i_init_done;
  end

  // Self-synchronous descrambler: each plain bit is the received bit XOR the
  // received bits 39 and 58 positions earlier.
  function automatic logic [63:0] descramble(input logic [63:0] rx, input logic [57:0] hist);
    logic [121:0] line;
    logic [63:0]  d;
    line = {rx, hist};
    for (int i = 0; i < 64; i++) d[i] = line[58 + i] ^ line[19 + i] ^ line[i];
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    int          exp_seq;
    int          nxt_seq;
    bit          first_frame;
    bit          have_lo;
    logic [57:0] rx_st;
    logic [31:0] lo_m, lo_b, prev_m, prev_b;
    logic [1:0]  hdr_lo, prev_hm;
    logic [63:0] blk_m, blk_b;
    exp_t        e;
    exp_seq = 0; nxt_seq = 0; first_frame = 1'b1; have_lo = 1'b0; rx_st = SEED;
    lo_m = '0; lo_b = '0; prev_m = '0; prev_b = '0; hdr_lo = '0; prev_hm = '0;
    forever begin
      @(negedge clk or negedge i_reset_n);
      if (mon_en && clk) begin
        // reset asserted while the clock is high: outputs must clear at once
        #1;
        chk("async_txd", 64'(m_txd), 64'd0);
        chk("async_hdr", 64'(m_hdr), 64'(SYNC_CTL));
        chk("async_seq", 64'(m_seq), 64'd0);
        chk("async_pause", 64'(m_pause), 64'd0);
        chk("async_byp_txd", 64'(b_txd), 64'd0);
      end else if (mon_en) begin
        if (!active_at_edge) begin
          chk("idle_txd", 64'(m_txd), 64'd0);
          chk("idle_hdr", 64'(m_hdr), 64'(SYNC_CTL));
          chk("idle_seq", 64'(m_seq), 64'd0);
          chk("idle_pause", 64'(m_pause), 64'd0);
          chk("idle_byp_txd", 64'(b_txd), 64'd0);
          nxt_seq = 1; first_frame = 1'b1; have_lo = 1'b0; rx_st = SEED;
        end else begin
          exp_seq = nxt_seq;
          chk("seq", 64'(m_seq), 64'(exp_seq));
          chk("pause", 64'(m_pause), 64'(exp_seq == 32));
          chk("byp_seq", 64'(b_seq), 64'(exp_seq));
          chk("byp_pause", 64'(b_pause), 64'(exp_seq == 32));
          if (exp_seq == 0) begin
            chk("pause_hold_txd", 64'(m_txd), 64'(prev_m));
            chk("pause_hold_hdr", 64'(m_hdr), 64'(prev_hm));
            chk("pause_hold_byp", 64'(b_txd), 64'(prev_b));
          end else if (exp_seq == 1 && first_frame) begin
            chk("first_upper_txd", 64'(m_txd), 64'd0);
            chk("first_upper_byp", 64'(b_txd), 64'd0);
          end else if (exp_seq % 2 == 0) begin
            lo_m = m_txd; lo_b = b_txd; hdr_lo = m_hdr; have_lo = 1'b1;
          end else if (have_lo) begin
            have_lo = 1'b0;
            chk("sb_depth_nonzero", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
              e = sb_q.pop_front();
              blk_m = {m_txd, lo_m};
              blk_b = {b_txd, lo_b};
              chk("byp_block", blk_b, e.blk);
              chk("descrambled", descramble(blk_m, rx_st), e.blk);
              rx_st = blk_m[63:6];
              chk("hdr_lower", 64'(hdr_lo), 64'(e.hdr));
              chk("hdr_upper", 64'(m_hdr), 64'(e.hdr));
              chk("byp_hdr", 64'(b_hdr), 64'(e.hdr));
              if (e.chk) begin
                chk("scr_lower", 64'(lo_m), 64'(e.lo));
                chk("scr_upper", 64'(m_txd), 64'(e.hi));
              end
            end
          end
          if (exp_seq == 32) first_frame = 1'b0;
          nxt_seq = (exp_seq == 32) ? 0 : exp_seq + 1;
        end
        prev_m = m_txd; prev_b = b_txd; prev_hm = m_hdr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    spos = (spos == 32) ? 0 : spos + 1;
  endtask

  // Holds one block for its two word slots; on the pause slot drives junk
  // first, which the DUT must ignore.
  task automatic present_block(input logic [63:0] blk, input logic [1:0] hdr,
                               input bit chk_scr, input logic [31:0] lo, input logic [31:0] hi);
    exp_t e;
    if (spos == 32) begin
      i_txd = {$urandom, $urandom};
      i_tx_header = 2'b11;
      step();
    end
    i_txd = blk;
    i_tx_header = hdr;
    step();
    e.blk = blk; e.hdr = hdr; e.chk = chk_scr; e.lo = lo; e.hi = hi;
    sb_q.push_back(e);
    step();
  endtask

  task automatic present_random();
    logic [63:0] blk;
    blk = {$urandom, $urandom};
    present_block(blk, ($urandom_range(0, 1) == 0) ? SYNC_DATA : SYNC_CTL, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin : stim
    i_reset_n = 1'b0;
    i_init_done = 1'b1;
    i_txd = '0;
    i_tx_header = SYNC_CTL;
    spos = 0;
    repeat (3) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    spos = 0;

    // first block after seed: all-zero data, scrambler on
    present_block(64'h0, SYNC_CTL, 1'b1, 32'h0000_0000, 32'h03FF_FF80);
    // bypass build must pass this straight through, lower word first
    present_block(64'h0123_4567_89AB_CDEF, SYNC_DATA, 1'b0, 32'h0, 32'h0);
    // random traffic across several pause windows
    for (int i = 0; i < 60; i++) present_random();

    // drop init during the upper-half slot of a block
    if (spos == 32) begin
      i_txd = {$urandom, $urandom};
      step();
    end
    i_txd = {$urandom, $urandom};
    step();
    i_init_done = 1'b0;
    step();
    i_init_done = 1'b1;
    spos = 0;
    present_block(64'h0, SYNC_CTL, 1'b1, 32'h0000_0000, 32'h03FF_FF80);
    for (int i = 0; i < 4; i++) present_random();

    // asynchronous reset in the middle of the high clock phase
    @(posedge clk);
    #3;
    i_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
